// File: rtl/nibble_serial_adder_pkg.sv
// Shared definitions for the nibble-serial adder: FSM state encoding and nibble width.
package nibble_serial_adder_pkg;

  localparam int NIB_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_add_slice.sv
// One 4-bit adder slice: generate/propagate, carry-lookahead carries, sum XOR.
module nibble_add_slice
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIB_W-1:0] a,
  input  logic [NIB_W-1:0] b,
  input  logic             ci,
  output logic [NIB_W-1:0] s,
  output logic             c3,
  output logic             c4
);

  logic [NIB_W-1:0] g;
  logic [NIB_W-1:0] p;
  logic [NIB_W-1:0] c;

  // Lookahead carries C1..C4 from per-bit generate/propagate and the incoming carry
  always_comb begin
    g    = a & b;
    p    = a | b;
    c[0] = ci;
    c[1] = g[0] | (p[0] & ci);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
    c4   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & ci);
    c3   = c[3];
    s    = a ^ b ^ c;
  end

endmodule

// File: rtl/nibble_serial_adder.sv
// Multi-cycle WIDTH-bit adder, one nibble per clock, LSB nibble first.
// Optional signed-overflow output enabled by NIBBLE_SERIAL_ADDER_OVF_EN.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  output logic             cout,
  output logic             ovf
`else
  output logic             cout
`endif
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             carry_q;
  logic [IDX_W-1:0] idx;
  logic             last;

  logic [NIB_W-1:0] nib_a;
  logic [NIB_W-1:0] nib_b;
  logic [NIB_W-1:0] nib_sum;
  logic             nib_c4;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             nib_c3;
  logic             ovf_q;
`endif

  assign nib_a = a_q[idx*NIB_W +: NIB_W];
  assign nib_b = b_q[idx*NIB_W +: NIB_W];
  assign last  = (idx == LAST_IDX);

  nibble_add_slice u_slice (
    .a  (nib_a),
    .b  (nib_b),
    .ci (carry_q),
    .s  (nib_sum),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .c3 (nib_c3),
`else
    .c3 (),
`endif
    .c4 (nib_c4)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = RUN;
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Operand capture and per-nibble accumulation; carry chains between nibbles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      idx     <= '0;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx     <= '0;
          end
        end
        RUN: begin
          sum_q[idx*NIB_W +: NIB_W] <= nib_sum;
          carry_q                   <= nib_c4;
          idx                       <= idx + 1'b1;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
          if (last) ovf_q <= nib_c4 ^ nib_c3;
`endif
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = carry_q;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (WIDTH=16), directed plus random operations.
module tb_nibble_serial_adder;

  localparam int WIDTH = 16;
  localparam int NIB   = WIDTH / 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
  logic             ovf;
`endif

  int total = 0;
  int bad   = 0;

  nibble_serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    .ovf       (ovf),
`endif
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction against the reference a+b+cin; optional operand scribbling
  // during RUN and a backpressure hold of 'hold' cycles in DONE.
  task automatic do_op(input logic [WIDTH-1:0] opa, input logic [WIDTH-1:0] opb,
                       input logic opc, input int hold, input bit scribble);
    logic [WIDTH:0]   full;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
    logic             exp_ovf;
    int               cycles;
    full     = {1'b0, opa} + {1'b0, opb} + {{WIDTH{1'b0}}, opc};
    exp_sum  = full[WIDTH-1:0];
    exp_cout = full[WIDTH];
    exp_ovf  = (opa[WIDTH-1] == opb[WIDTH-1]) && (exp_sum[WIDTH-1] != opa[WIDTH-1]);

    check("idle_in_ready", in_ready, 1);
    a = opa; b = opb; cin = opc; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    cycles = 0;
    while (!out_valid && cycles < 20) begin
      check("run_in_ready", in_ready, 0);
      if (scribble) begin
        a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
      end
      tick();
      cycles++;
    end
    check("latency", cycles, NIB);
    check("sum", sum, exp_sum);
    check("cout", cout, exp_cout);
`ifdef NIBBLE_SERIAL_ADDER_OVF_EN
    check("ovf", ovf, exp_ovf);
`else
    if (exp_ovf) total += 0;
`endif
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      a = WIDTH'($urandom); b = WIDTH'($urandom);
      tick();
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_sum", sum, exp_sum);
      check("hold_cout", cout, exp_cout);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_valid", out_valid, 0);
    check("release_in_ready", in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    #6 rst_n = 1'b1;
    tick();

    do_op(16'h1234, 16'h4321, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'hFFFF, 16'h0000, 1'b1, 0, 1'b0);
    do_op(16'h1234, 16'h4321, 1'b0, 5, 1'b0);
    do_op(16'h00F0, 16'h0010, 1'b0, 0, 1'b1);
    do_op(16'h7FFF, 16'h0001, 1'b0, 0, 1'b0);
    do_op(16'h8000, 16'h8000, 1'b0, 1, 1'b0);

    // Abort two edges into RUN
    a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    check("abort_sum", sum, 0);
    check("abort_cout", cout, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    #2 rst_n = 1'b1;
    tick();
    check("abort_still_idle", out_valid, 0);
    do_op(16'h0001, 16'h0001, 1'b0, 0, 1'b0);

    for (int n = 0; n < 24; n++)
      do_op(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder.md
Name: nibble_serial_adder

Overview:
- Multi-cycle WIDTH-bit adder built around the 4-bit carry-lookahead unit.
- Feeds the CLA with per-nibble generate/propagate signals (upstream role) and consumes its C1..C4 to form sum bits (downstream role).
- Processes one 4-bit nibble per clock, LSB nibble first, with a registered carry chaining nibbles.
- Valid/ready handshake on both input and output sides.

Parameters:
- WIDTH, 16, operand width in bits; must be a multiple of 4 and at least 4.
- NIB, WIDTH/4 (derived localparam), number of nibble cycles per operation.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand bundle valid.
- in_ready  out  1  block can accept operands.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry into bit 0.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- sum  out  WIDTH  a+b+cin, low WIDTH bits.
- cout  out  1  carry out of bit WIDTH-1.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; in_ready=1, out_valid=0, sum=0, cout=0.
  - Internal operand, carry and index registers cleared.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - An edge with in_valid=1 latches a, b and cin (cin goes into the carry register), sets idx=0, and moves to RUN.
- RUN:
  - in_ready=0.
  - Each edge processes nibble idx:
    - g[i]=a[i]&b[i], p[i]=a[i]|b[i].
    - CLA carries use the carry register as cin.
    - sum bit i = a[i]^b[i]^c[i], where c[0] is the carry register and c[1..3] are C1..C3.
  - Sum nibble is written into sum[4*idx+3:4*idx]; the carry register takes C4; idx increments.
  - When idx==NIB-1, go to DONE.
- DONE:
  - out_valid=1; sum and cout (the final carry register) are stable.
  - On an edge with out_ready=1: out_valid drops and the state returns to IDLE.
  - While out_ready=0, sum, cout and out_valid hold indefinitely.
  - in_valid is ignored in DONE; no overlap with the next operation.
- Latency:
  - out_valid rises exactly NIB edges after the accepting edge (4 for WIDTH=16).
  - Throughput: one operation per NIB+2 cycles minimum.
- Sum register: written nibble by nibble; content is defined only while out_valid=1.
- Operand changes on a/b/cin after acceptance have no effect.
- WIDTH=4: a single RUN cycle.
- Reset asserted mid-RUN or in DONE aborts the operation and returns all outputs to reset values; no partial result is ever presented.

Optional Feature:
- Macro: NIBBLE_SERIAL_ADDER_OVF_EN.
- When defined, an extra output port ovf (1 bit) is present:
  - Computed as the signed overflow of the final nibble: C4 XOR C3 of the last RUN cycle.
  - Registered with the sum; valid with out_valid; reset value 0.
- When undefined: no ovf port and no extra logic; behaviour is otherwise identical.

Decomposition:
- Shared package/include nibble_serial_adder_defs, containing:
  - State encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - Localparam NIB_W=4.
- One natural sub-module, nibble_add_slice:
  - Combinational 4-bit g/p generation, the existing CLA instance, and sum XOR.
  - Outputs: 4-bit sum and C4.
  - Also outputs C3 for the optional overflow flag.

Test Plan (WIDTH=16):
- Basic add: a=0x1234, b=0x4321, cin=0 -> sum=0x5555, cout=0, out_valid high exactly 4 edges after acceptance.
- Full ripple across nibbles: a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1. A second run with a=0xFFFF, b=0x0000, cin=1 gives the same result.
- Backpressure and handshake:
  - Hold out_ready=0 for 5 cycles after out_valid -> sum=0x5555 held, in_ready=0 throughout.
  - Raise out_ready -> out_valid=0 and in_ready=1 on the next edge.
- Reset mid-operation: assert rst_n=0 two edges into RUN -> sum=0, cout=0, out_valid=0, in_ready=1 immediately. A following add of 0x0001+0x0001 yields 0x0002.
- Operand isolation: change a/b every cycle during RUN after accepting 0x00F0+0x0010 -> sum=0x0100, cout=0.
- With NIBBLE_SERIAL_ADDER_OVF_EN defined:
  - 0x7FFF+0x0001 -> sum=0x8000, ovf=1, cout=0.
  - 0xFFFF+0x0001 -> ovf=0.
